// File: rtl/term_pkg.sv
// Shared geometry, control codes and state encoding for the terminal writer.
// The character RAM holds ROWS*COLS cells addressed as phys_row*COLS+col.
package term_pkg;

  localparam int COLS = 64;
  localparam int ROWS = 40;
  localparam logic [7:0] BLANK = 8'h20;

  localparam int CELLS  = ROWS * COLS;
  localparam int ADDR_W = $clog2(CELLS);
  localparam int ROW_W  = $clog2(ROWS);
  localparam int COL_W  = $clog2(COLS);

  localparam logic [7:0] ASCII_BS = 8'h08;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_FF = 8'h0C;
  localparam logic [7:0] ASCII_CR = 8'h0D;

  typedef enum logic [1:0] {
    CLR_ALL,
    IDLE,
    CLR_LINE
  } state_t;

endpackage

// File: rtl/terminal_writer.sv
// Turns an ASCII byte stream into character-RAM writes, tracking the cursor
// and a circular top row so scrolling only needs one line cleared.
module terminal_writer
  import term_pkg::*;
(
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [7:0]        char_in,
  input  logic              char_valid_in,
  output logic              char_ready_out,
  output logic              wr_en_out,
  output logic [ADDR_W-1:0] wr_addr_out,
  output logic [7:0]        wr_data_out,
  output logic [ROW_W-1:0]  top_row_out,
  output logic [ROW_W-1:0]  cursor_row_out,
  output logic [COL_W-1:0]  cursor_col_out,
  output logic              busy_out
);

  state_t            state_reg, state_next;
  logic [ROW_W-1:0]  top_reg, top_next;
  logic [ROW_W-1:0]  row_reg, row_next;
  logic [COL_W-1:0]  col_reg, col_next;
  logic [ROW_W-1:0]  clr_row_reg, clr_row_next;
  logic [ADDR_W-1:0] cnt_reg, cnt_next;
  logic              wr_en_reg, wr_en_next;
  logic [ADDR_W-1:0] wr_addr_reg, wr_addr_next;
  logic [7:0]        wr_data_reg, wr_data_next;

  logic [ROW_W:0]    row_sum;
  logic [ROW_W-1:0]  phys_row;
  logic [ADDR_W-1:0] row_base;
  logic              newline;

  // Screen row to physical RAM row; ROWS need not be a power of two.
  assign row_sum  = {1'b0, top_reg} + {1'b0, row_reg};
  assign phys_row = (row_sum >= (ROW_W+1)'(ROWS)) ? ROW_W'(row_sum - (ROW_W+1)'(ROWS))
                                                  : ROW_W'(row_sum);
  assign row_base = ADDR_W'(phys_row) * ADDR_W'(COLS);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_reg   <= CLR_ALL;
      top_reg     <= '0;
      row_reg     <= '0;
      col_reg     <= '0;
      clr_row_reg <= '0;
      cnt_reg     <= '0;
      wr_en_reg   <= 1'b0;
      wr_addr_reg <= '0;
      wr_data_reg <= '0;
    end else begin
      state_reg   <= state_next;
      top_reg     <= top_next;
      row_reg     <= row_next;
      col_reg     <= col_next;
      clr_row_reg <= clr_row_next;
      cnt_reg     <= cnt_next;
      wr_en_reg   <= wr_en_next;
      wr_addr_reg <= wr_addr_next;
      wr_data_reg <= wr_data_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    top_next     = top_reg;
    row_next     = row_reg;
    col_next     = col_reg;
    clr_row_next = clr_row_reg;
    cnt_next     = cnt_reg;
    wr_en_next   = 1'b0;
    wr_addr_next = wr_addr_reg;
    wr_data_next = wr_data_reg;
    newline      = 1'b0;

    case (state_reg)
      CLR_ALL: begin
        wr_en_next   = 1'b1;
        wr_addr_next = cnt_reg;
        wr_data_next = BLANK;
        if (cnt_reg == ADDR_W'(CELLS - 1)) begin
          cnt_next   = '0;
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      CLR_LINE: begin
        wr_en_next   = 1'b1;
        wr_addr_next = ADDR_W'(clr_row_reg) * ADDR_W'(COLS) + cnt_reg;
        wr_data_next = BLANK;
        if (cnt_reg == ADDR_W'(COLS - 1)) begin
          cnt_next   = '0;
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      IDLE: begin
        if (char_valid_in) begin
          if (char_in >= 8'h20 && char_in <= 8'h7E) begin
            wr_en_next   = 1'b1;
            wr_addr_next = row_base + ADDR_W'(col_reg);
            wr_data_next = char_in;
            if (col_reg == COL_W'(COLS - 1)) begin
              col_next = '0;
              newline  = 1'b1;
            end else begin
              col_next = col_reg + 1'b1;
            end
          end else if (char_in == ASCII_LF) begin
            col_next = '0;
            newline  = 1'b1;
          end else if (char_in == ASCII_CR) begin
            col_next = '0;
          end else if (char_in == ASCII_BS) begin
            if (col_reg != '0) begin
              col_next     = col_reg - 1'b1;
              wr_en_next   = 1'b1;
              wr_addr_next = row_base + ADDR_W'(col_reg - 1'b1);
              wr_data_next = BLANK;
            end
          end else if (char_in == ASCII_FF) begin
            row_next   = '0;
            col_next   = '0;
            top_next   = '0;
            cnt_next   = '0;
            state_next = CLR_ALL;
          end
        end
      end

      default: state_next = CLR_ALL;
    endcase

    // Scroll: the old top row becomes the new bottom line and must be blanked.
    if (newline) begin
      if (row_reg < ROW_W'(ROWS - 1)) begin
        row_next = row_reg + 1'b1;
      end else begin
        top_next     = (top_reg == ROW_W'(ROWS - 1)) ? '0 : top_reg + 1'b1;
        clr_row_next = top_reg;
        cnt_next     = '0;
        state_next   = CLR_LINE;
      end
    end
  end

  assign char_ready_out = (state_reg == IDLE);
  assign busy_out       = (state_reg != IDLE);
  assign wr_en_out      = wr_en_reg;
  assign wr_addr_out    = wr_addr_reg;
  assign wr_data_out    = wr_data_reg;
  assign top_row_out    = top_reg;
  assign cursor_row_out = row_reg;
  assign cursor_col_out = col_reg;

endmodule

// File: tb/tb_terminal_writer.sv
// Randomized self-checking bench: a screen-level model predicts the RAM writes
// and cursor position for every byte sent to terminal_writer.
module tb_terminal_writer;
  import term_pkg::*;

  logic              clk_in = 1'b0;
  logic              rst_in = 1'b0;
  logic [7:0]        char_in = 8'h00;
  logic              char_valid_in = 1'b0;
  logic              char_ready_out;
  logic              wr_en_out;
  logic [ADDR_W-1:0] wr_addr_out;
  logic [7:0]        wr_data_out;
  logic [ROW_W-1:0]  top_row_out;
  logic [ROW_W-1:0]  cursor_row_out;
  logic [COL_W-1:0]  cursor_col_out;
  logic              busy_out;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: cursor, top row and the list of writes a byte should cause.
  int m_row = 0, m_col = 0, m_top = 0;
  int exp_addr[$];
  logic [7:0] exp_data[$];
  int obs_addr[$];
  logic [7:0] obs_data[$];
  int ready_low;

  terminal_writer dut (
    .clk_in(clk_in), .rst_in(rst_in), .char_in(char_in), .char_valid_in(char_valid_in),
    .char_ready_out(char_ready_out), .wr_en_out(wr_en_out), .wr_addr_out(wr_addr_out),
    .wr_data_out(wr_data_out), .top_row_out(top_row_out), .cursor_row_out(cursor_row_out),
    .cursor_col_out(cursor_col_out), .busy_out(busy_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic model_clear_screen();
    m_row = 0; m_col = 0; m_top = 0;
    for (int i = 0; i < 64 * 40; i++) begin
      exp_addr.push_back(i); exp_data.push_back(8'h20);
    end
  endtask

  task automatic model_newline();
    if (m_row < 39) m_row++;
    else begin
      for (int i = 0; i < 64; i++) begin
        exp_addr.push_back(m_top * 64 + i); exp_data.push_back(8'h20);
      end
      m_top = (m_top + 1) % 40;
    end
  endtask

  task automatic model_char(input logic [7:0] b);
    int phys;
    phys = (m_top + m_row) % 40;
    if (b >= 8'h20 && b <= 8'h7E) begin
      exp_addr.push_back(phys * 64 + m_col); exp_data.push_back(b);
      m_col++;
      if (m_col == 64) begin m_col = 0; model_newline(); end
    end else if (b == 8'h0A) begin
      m_col = 0; model_newline();
    end else if (b == 8'h0D) begin
      m_col = 0;
    end else if (b == 8'h08) begin
      if (m_col > 0) begin
        m_col--;
        exp_addr.push_back(phys * 64 + m_col); exp_data.push_back(8'h20);
      end
    end else if (b == 8'h0C) begin
      model_clear_screen();
    end
  endtask

  // Gathers writes seen on each falling edge until the block is ready again.
  task automatic collect();
    int n;
    n = 0; ready_low = 0;
    do begin
      @(negedge clk_in);
      if (wr_en_out) begin obs_addr.push_back(int'(wr_addr_out)); obs_data.push_back(wr_data_out); end
      if (!char_ready_out) ready_low++;
      n++;
    end while (!char_ready_out && n < 3000);
    vectors++;
    if (!char_ready_out) begin
      miscompares++;
      $display("FAIL ready_timeout: ready=%0b after %0d cycles, want 1", char_ready_out, n);
    end
  endtask

  // Sends one byte (caller is at a falling edge with ready high), collects and models it.
  task automatic apply(input logic [7:0] b);
    obs_addr.delete(); obs_data.delete(); exp_addr.delete(); exp_data.delete();
    char_in = b; char_valid_in = 1'b1;
    @(posedge clk_in); #1 char_valid_in = 1'b0;
    collect();
    model_char(b);
    $display("tx byte=%02h writes=%0d row=%0d col=%0d top=%0d",
             b, obs_addr.size(), cursor_row_out, cursor_col_out, top_row_out);
  endtask

  task automatic test_reset();
    #1;
    vectors++;
    if ({char_ready_out, busy_out, wr_en_out, wr_addr_out, wr_data_out, top_row_out,
         cursor_row_out, cursor_col_out} !== {1'b0, 1'b1, 1'b0, {ADDR_W{1'b0}}, 8'h00,
         {ROW_W{1'b0}}, {ROW_W{1'b0}}, {COL_W{1'b0}}}) begin
      miscompares++;
      $display("FAIL reset_outputs: ready=%0b busy=%0b wr_en=%0b addr=%0d data=%02h, want 0 1 0 0 00",
               char_ready_out, busy_out, wr_en_out, wr_addr_out, wr_data_out);
    end
    @(negedge clk_in); @(negedge clk_in);
    rst_in = 1'b1;
    obs_addr.delete(); obs_data.delete(); exp_addr.delete(); exp_data.delete();
    collect();
    model_clear_screen();
    vectors++;
    if (obs_addr.size() != exp_addr.size()) begin
      miscompares++;
      $display("FAIL reset_clear_count: got %0d writes, want %0d", obs_addr.size(), exp_addr.size());
    end
    for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++) begin
      vectors++;
      if (obs_addr[i] != exp_addr[i] || obs_data[i] !== exp_data[i]) begin
        miscompares++;
        $display("FAIL reset_clear[%0d]: got %02h@%0d, want %02h@%0d", i, obs_data[i], obs_addr[i], exp_data[i], exp_addr[i]);
      end
    end
    vectors++;
    if (busy_out !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle_busy: busy=%0b, want 0", busy_out);
    end
  endtask

  // Sends a list of bytes and checks every write and the final cursor of each one.
  task automatic test_sequence(input string name, input logic [7:0] bytes_q[$]);
    foreach (bytes_q[k]) begin
      apply(bytes_q[k]);
      vectors++;
      if (obs_addr.size() != exp_addr.size()) begin
        miscompares++;
        $display("FAIL %s_count[%0d]: got %0d writes, want %0d", name, k, obs_addr.size(), exp_addr.size());
      end
      for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++) begin
        vectors++;
        if (obs_addr[i] != exp_addr[i] || obs_data[i] !== exp_data[i]) begin
          miscompares++;
          $display("FAIL %s_write[%0d.%0d]: got %02h@%0d, want %02h@%0d", name, k, i, obs_data[i], obs_addr[i], exp_data[i], exp_addr[i]);
        end
      end
      vectors++;
      if (int'(cursor_row_out) != m_row || int'(cursor_col_out) != m_col || int'(top_row_out) != m_top) begin
        miscompares++;
        $display("FAIL %s_cursor[%0d]: got row=%0d col=%0d top=%0d, want row=%0d col=%0d top=%0d",
                 name, k, cursor_row_out, cursor_col_out, top_row_out, m_row, m_col, m_top);
      end
    end
  endtask

  task automatic test_printable();
    logic [7:0] q[$];
    q = '{8'h41};
    test_sequence("printable", q);
  endtask

  task automatic test_line_wrap();
    logic [7:0] q[$];
    q.push_back(8'h0C);
    for (int i = 0; i < 64; i++) q.push_back(8'h42);
    test_sequence("line_wrap", q);
  endtask

  task automatic test_backspace();
    logic [7:0] q[$];
    q = '{8'h0C, 8'h43, 8'h08, 8'h08, 8'h0D};
    test_sequence("backspace", q);
  endtask

  task automatic test_scroll();
    logic [7:0] q[$];
    q.push_back(8'h0C);
    for (int i = 0; i < 39; i++) q.push_back(8'h0A);
    test_sequence("scroll_fill", q);
    q = '{8'h0A};
    test_sequence("scroll", q);
    vectors++;
    if (ready_low != 64) begin
      miscompares++;
      $display("FAIL scroll_ready_low: got %0d cycles, want 64", ready_low);
    end
    q = '{8'h44};
    test_sequence("after_scroll", q);
  endtask

  task automatic test_random();
    logic [7:0] q[$];
    int r;
    for (int i = 0; i < 250; i++) begin
      r = $urandom_range(0, 99);
      if (r < 60)      q.push_back(8'($urandom_range(8'h20, 8'h7E)));
      else if (r < 70) q.push_back(8'h0A);
      else if (r < 78) q.push_back(8'h0D);
      else if (r < 88) q.push_back(8'h08);
      else if (r < 93) q.push_back(8'($urandom_range(8'h80, 8'hFF)));
      else if (r < 98) q.push_back(8'h1B);
      else             q.push_back(8'h0C);
    end
    test_sequence("random", q);
  endtask

  task automatic test_reset_midclear();
    logic [7:0] q[$];
    q.push_back(8'h0C);
    for (int i = 0; i < 39; i++) q.push_back(8'h0A);
    test_sequence("midclear_fill", q);
    char_in = 8'h0A; char_valid_in = 1'b1;
    repeat (10) @(negedge clk_in);
    #2 rst_in = 1'b0;
    #1;
    vectors++;
    if ({char_ready_out, busy_out, wr_en_out, wr_addr_out, wr_data_out, top_row_out,
         cursor_row_out, cursor_col_out} !== {1'b0, 1'b1, 1'b0, {ADDR_W{1'b0}}, 8'h00,
         {ROW_W{1'b0}}, {ROW_W{1'b0}}, {COL_W{1'b0}}}) begin
      miscompares++;
      $display("FAIL midclear_reset: ready=%0b busy=%0b wr_en=%0b addr=%0d top=%0d row=%0d, want 0 1 0 0 0 0",
               char_ready_out, busy_out, wr_en_out, wr_addr_out, top_row_out, cursor_row_out);
    end
    repeat (3) @(negedge clk_in);
    char_in = 8'h41;
    rst_in = 1'b1;
    obs_addr.delete(); obs_data.delete(); exp_addr.delete(); exp_data.delete();
    collect();
    model_clear_screen();
    vectors++;
    if (obs_addr.size() != exp_addr.size()) begin
      miscompares++;
      $display("FAIL midclear_count: got %0d writes, want %0d", obs_addr.size(), exp_addr.size());
    end
    for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++) begin
      vectors++;
      if (obs_addr[i] != exp_addr[i] || obs_data[i] !== exp_data[i]) begin
        miscompares++;
        $display("FAIL midclear_write[%0d]: got %02h@%0d, want %02h@%0d", i, obs_data[i], obs_addr[i], exp_data[i], exp_addr[i]);
      end
    end
    // The byte held valid throughout is taken on the first ready edge.
    @(posedge clk_in); #1 char_valid_in = 1'b0;
    @(negedge clk_in);
    vectors++;
    if (wr_en_out !== 1'b1 || wr_addr_out !== '0 || wr_data_out !== 8'h41 || cursor_col_out !== COL_W'(1)) begin
      miscompares++;
      $display("FAIL midclear_held_char: wr_en=%0b addr=%0d data=%02h col=%0d, want 1 0 41 1",
               wr_en_out, wr_addr_out, wr_data_out, cursor_col_out);
    end
  endtask

  initial begin
    test_reset();
    test_printable();
    test_line_wrap();
    test_backspace();
    test_scroll();
    test_random();
    test_reset_midclear();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/terminal_writer.md
Name: terminal_writer

Overview:
- Upstream feeder of the character_sprites renderer. Consumes a byte stream of ASCII characters over a valid/ready handshake.
- Maintains the cursor and handles control codes and scrolling.
- Drives the write port of the character RAM that the renderer reads, plus the circular-buffer base row the renderer uses to map screen rows to physical RAM rows.
- Runs in the pixel clock domain next to video_sig_gen.

Parameters:
- COLS, 64, characters per row (1280 px / 20 px glyph).
- ROWS, 40, character rows (720 px / 18 px glyph).
- BLANK, 8'h20, code written when clearing cells.

Ports:
- clk_in  input  1  pixel clock; every register in the block is clocked by it.
- rst_in  input  1  reset, asynchronous assert, active-low.
- char_in  input  8  ASCII byte.
- char_valid_in  input  1  char_in is valid.
- char_ready_out  output  1  block accepts char_in this cycle.
- wr_en_out  output  1  character RAM write strobe.
- wr_addr_out  output  $clog2(ROWS*COLS)  write address, phys_row*COLS+col.
- wr_data_out  output  8  byte to write.
- top_row_out  output  $clog2(ROWS)  physical RAM row shown on screen row 0.
- cursor_row_out  output  $clog2(ROWS)  logical cursor row (0 = top of screen).
- cursor_col_out  output  $clog2(COLS)  cursor column.
- busy_out  output  1  a clear is in progress.

Behaviour:
- Reset (rst_in low, async):
  - All outputs go to 0: wr_en, wr_addr, wr_data, top_row, cursor, char_ready.
  - busy_out goes to 1, and state goes to CLR_ALL.
- State CLR_ALL:
  - Writes BLANK to addresses 0..ROWS*COLS-1, one per cycle.
  - wr_en=1 for exactly ROWS*COLS cycles, then goes to IDLE.
- State IDLE:
  - char_ready_out=1 and busy_out=0.
  - A transfer occurs when valid && ready. It is processed in the same cycle, and its write (if any) appears registered on the next cycle (latency 1).
- State CLR_LINE:
  - Writes BLANK to the COLS cells of one physical row, address incrementing by 1.
  - Returns to IDLE after the last cell.
- char_ready_out=0 in every state except IDLE. No input is lost: a producer holding valid waits.
- Physical row is phys_row = (top_row + cursor_row) mod ROWS. Both the add and the wrap are explicit, with no power-of-2 assumption.
- Character handling:
  - 0x20..0x7E: write the char at (phys_row, col), then col+1. If col was COLS-1, wrap: col=0 and newline.
  - 0x0A (LF): col=0, newline.
  - 0x0D (CR): col=0, no write.
  - 0x08 (BS), col>0: col-1 and write BLANK at the new position.
  - 0x08 (BS), col==0: no-op. There is no reverse wrap.
  - 0x0C (FF): cursor home, top_row=0, go to CLR_ALL.
  - Any other byte: consumed and ignored, no write.
- Newline:
  - If cursor_row < ROWS-1: cursor_row+1.
  - Otherwise scroll: top_row = (top_row+1) mod ROWS, cursor_row stays ROWS-1, and the newly exposed physical row (the old top_row) is cleared in CLR_LINE.
  - The printable-at-last-column case writes its char on the cycle after acceptance; the line clear follows on the next cycles.
- wr_en_out is high only for printable-char writes, BS blanks, and clear cycles. wr_addr/wr_data hold their last value otherwise.
- Cursor outputs are updated in the cycle after acceptance.
- Reset asserted mid-clear aborts it immediately. On release, a full CLR_ALL restarts.

Decomposition:
- term_pkg holds:
  - COLS, ROWS, BLANK.
  - Control-code constants: ASCII_LF, ASCII_CR, ASCII_BS, ASCII_FF.
  - The state enum {CLR_ALL, IDLE, CLR_LINE}.
  - Address/row/col widths.
- Single module; no sub-module is natural. Row-wrap arithmetic stays inline.

Test Plan:
- Release reset -> char_ready_out=0, busy_out=1, and wr_en high for exactly 2560 cycles with data 0x20, addresses 0..2559 in order. Then ready=1 and busy=0.
- Send 0x41 at home -> next cycle wr_en=1, addr=0, data=0x41; cursor_col=1.
- Send 64 × 0x42 from home -> last write at addr 63; cursor row=1, col=0, no scroll.
- Send 0x43 then 0x08 -> writes 0x43 to addr 0, then 0x20 to addr 0; col=0. A further 0x08 -> no write, col stays 0.
- Send 40 × 0x0A from home:
  - After the 39th, cursor_row=39.
  - The 40th gives top_row=1 and ready=0 for 64 cycles, with addresses 0..63 written 0x20.
  - A following 0x44 writes addr 0 (phys row 0), with cursor_row still 39.
- Assert rst_in low midway through CLR_LINE with valid held high -> outputs drop to reset values asynchronously. After release, CLR_ALL runs for 2560 cycles and no char is accepted until it ends.
